// File: rtl/pulse_sequencer_if.sv
// Requester/generator signal bundle for pulse_sequencer.
// Handshake: req is a level held by each requester. A job is accepted on the rising edge where the
// sequencer is idle and req != 0, and grant pulses one-hot for exactly the following LOAD cycle.
// Withdrawing req after acceptance has no effect on the running job.
interface pulse_sequencer_if #(
    parameter int PAT_W = 16,
    parameter int REP_W = 4
);
    logic [1:0]       req;
    logic [PAT_W-1:0] pattern0;
    logic [PAT_W-1:0] pattern1;
    logic [REP_W-1:0] repeats0;
    logic [REP_W-1:0] repeats1;
    logic             abort;
    logic [1:0]       grant;
    logic             owner;
    logic [PAT_W-1:0] pg_in;
    logic             pg_load;
    logic             busy;
    logic             done;

    modport master (
        output req, pattern0, pattern1, repeats0, repeats1, abort,
        input  grant, owner, pg_in, pg_load, busy, done
    );

    modport slave (
        input  req, pattern0, pattern1, repeats0, repeats1, abort,
        output grant, owner, pg_in, pg_load, busy, done
    );
endinterface

// File: rtl/pulse_sequencer.sv
// Arbitrates two requesters and runs one pulse-generator job: LOAD, then 16*(repeats+1) RUN cycles, then DONE.
// Define PULSE_SEQ_ROUND_ROBIN_EN to alternate winners on simultaneous requests; otherwise requester 0 has fixed priority.
module pulse_sequencer #(
    parameter int PAT_W = 16,
    parameter int REP_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    pulse_sequencer_if.slave   bus,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [REP_W-1:0] rot_q, rot_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [PAT_W-1:0] pg_in_q, pg_in_d;
    logic             owner_q, owner_d;
    logic [1:0]       grant_q, grant_d;
    logic             pg_load_q, pg_load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             winner;

`ifdef PULSE_SEQ_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the requester not granted last wins; a lone request always wins.
    always_comb begin
        winner = ~bus.req[0];
        if (bus.req == 2'b11) begin
            winner = ~last_q;
        end
    end
`else
    assign winner = ~bus.req[0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rot_d     = rot_q;
        rep_d     = rep_q;
        pg_in_d   = pg_in_q;
        owner_d   = owner_q;
        grant_d   = 2'b00;
        pg_load_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef PULSE_SEQ_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d   = S_LOAD;
                    owner_d   = winner;
                    pg_in_d   = winner ? bus.pattern1 : bus.pattern0;
                    rep_d     = winner ? bus.repeats1 : bus.repeats0;
                    grant_d   = winner ? 2'b10 : 2'b01;
                    pg_load_d = 1'b1;
                    busy_d    = 1'b1;
`ifdef PULSE_SEQ_ROUND_ROBIN_EN
                    last_d    = winner;
`endif
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                    rot_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // Abort outranks the final-cycle completion check.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    busy_d = 1'b1;
                    if (cnt_q == 4'd15) begin
                        if (rot_q == rep_q) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            rot_d = rot_q + REP_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rot_q     <= '0;
            rep_q     <= '0;
            pg_in_q   <= '0;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            pg_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PULSE_SEQ_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rot_q     <= rot_d;
            rep_q     <= rep_d;
            pg_in_q   <= pg_in_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            pg_load_q <= pg_load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PULSE_SEQ_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.pg_in   = pg_in_q;
    assign bus.pg_load = pg_load_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed-plus-random bench for pulse_sequencer, checked against a job-level timeline model.
// Build with or without PULSE_SEQ_ROUND_ROBIN_EN; the model follows the same define.
module tb_pulse_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;
    int         vectors = 0;
    int         miscompares = 0;
    logic       last_m = 1'b1;
    logic [1:0] exp_q[$];

    pulse_sequencer_if #(.PAT_W(16), .REP_W(4)) bus ();

    pulse_sequencer #(.PAT_W(16), .REP_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] g, input logic ld,
                           input logic b, input logic d);
        chk({tag, ".grant"},   32'(bus.grant),   32'(g));
        chk({tag, ".pg_load"}, 32'(bus.pg_load), 32'(ld));
        chk({tag, ".busy"},    32'(bus.busy),    32'(b));
        chk({tag, ".done"},    32'(bus.done),    32'(d));
    endtask

    task automatic chk_zero(input string tag);
        chk_out(tag, 2'b00, 1'b0, 1'b0, 1'b0);
        chk({tag, ".owner"}, 32'(bus.owner), 32'd0);
        chk({tag, ".pg_in"}, 32'(bus.pg_in), 32'd0);
    endtask

    // One job from the acceptance edge to the idle cycle after it.
    // kill_at: position in the busy window (0 = LOAD, k = RUN cycle k-1) where abort or reset hits; -1 = none.
    task automatic run_job(input logic [1:0] r, input logic [15:0] p0, input logic [15:0] p1,
                           input logic [3:0] r0, input logic [3:0] r1,
                           input int kill_at, input bit kill_rst, input bit abort_idle);
        logic        w;
        logic [15:0] pat;
        logic [1:0]  g;
        int          run_len;
        if (r == 2'b01) w = 1'b0;
        else if (r == 2'b10) w = 1'b1;
        else begin
`ifdef PULSE_SEQ_ROUND_ROBIN_EN
            w = ~last_m;
`else
            w = 1'b0;
`endif
        end
        last_m  = w;
        pat     = w ? p1 : p0;
        run_len = 16 * ((w ? int'(r1) : int'(r0)) + 1);
        exp_q.push_back(w ? 2'b10 : 2'b01);

        bus.req      = r;
        bus.pattern0 = p0;
        bus.pattern1 = p1;
        bus.repeats0 = r0;
        bus.repeats1 = r1;
        bus.abort    = abort_idle;
        @(posedge clock); #1;
        for (int p = 0; p <= run_len; p++) begin
            if (p == 0) begin
                g = exp_q.pop_front();
                chk_out("load", g, 1'b1, 1'b1, 1'b0);
            end else begin
                chk_out($sformatf("run%0d", p - 1), 2'b00, 1'b0, 1'b1, 1'b0);
            end
            chk($sformatf("owner@%0d", p), 32'(bus.owner), 32'(w));
            chk($sformatf("pg_in@%0d", p), 32'(bus.pg_in), 32'(pat));
            bus.req      = 2'($urandom_range(0, 3));
            bus.pattern0 = 16'($urandom);
            bus.pattern1 = 16'($urandom);
            bus.repeats0 = 4'($urandom);
            bus.repeats1 = 4'($urandom);
            bus.abort    = 1'b0;
            if (p == kill_at) begin
                bus.abort = 1'b1;
                if (kill_rst) begin
                    reset   = 1'b1;
                    bus.req = 2'b11;
                end else begin
                    bus.req = 2'b00;
                end
                @(posedge clock); #1;
                if (kill_rst) begin
                    chk_zero("reset_kill");
                    last_m = 1'b1;
                end else begin
                    chk_out("abort_kill", 2'b00, 1'b0, 1'b0, 1'b0);
                end
                reset     = 1'b0;
                bus.abort = 1'b0;
                bus.req   = 2'b00;
                @(posedge clock); #1;
                chk_out("after_kill", 2'b00, 1'b0, 1'b0, 1'b0);
                return;
            end
            @(posedge clock); #1;
        end
        chk_out("done", 2'b00, 1'b0, 1'b0, 1'b1);
        bus.req   = 2'($urandom_range(1, 3));
        bus.abort = 1'($urandom);
        @(posedge clock); #1;
        chk_out("post_done_idle", 2'b00, 1'b0, 1'b0, 1'b0);
        bus.abort = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = 2'b11;
        bus.abort    = 1'b1;
        bus.pattern0 = 16'($urandom);
        bus.pattern1 = 16'($urandom);
        bus.repeats0 = 4'($urandom);
        bus.repeats1 = 4'($urandom);
        repeat (2) begin
            @(posedge clock); #1;
            chk_zero("reset");
        end
        reset     = 1'b0;
        bus.req   = 2'b00;
        bus.abort = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            chk_out("idle_no_req", 2'b00, 1'b0, 1'b0, 1'b0);
        end

        // Single short job with a fixed pattern.
        run_job(2'b01, 16'h8001, 16'($urandom), 4'd0, 4'($urandom), -1, 1'b0, 1'b0);
        // Both requesting for three jobs.
        repeat (3) run_job(2'b11, 16'($urandom), 16'($urandom), 4'd0, 4'd0, -1, 1'b0, 1'b0);
        // Longest job, then the same aborted on RUN cycle 100.
        run_job(2'b10, 16'($urandom), 16'($urandom), 4'($urandom), 4'hF, -1, 1'b0, 1'b0);
        run_job(2'b10, 16'($urandom), 16'($urandom), 4'($urandom), 4'hF, 101, 1'b0, 1'b0);
        // Reset on RUN cycle 5, then a fresh job.
        run_job(2'b01, 16'($urandom), 16'($urandom), 4'd2, 4'($urandom), 6, 1'b1, 1'b0);
        run_job(2'b01, 16'($urandom), 16'($urandom), 4'd0, 4'($urandom), -1, 1'b0, 1'b0);
        // Abort on the very last RUN cycle of a repeats=1 job.
        run_job(2'b01, 16'($urandom), 16'($urandom), 4'd1, 4'($urandom), 32, 1'b0, 1'b0);
        // Abort and reset landing in LOAD.
        run_job(2'b11, 16'($urandom), 16'($urandom), 4'd0, 4'd0, 0, 1'b0, 1'b0);
        run_job(2'b11, 16'($urandom), 16'($urandom), 4'd0, 4'd0, 0, 1'b1, 1'b0);
        // Abort while idle must not block acceptance.
        run_job(2'b10, 16'($urandom), 16'($urandom), 4'($urandom), 4'd0, -1, 1'b0, 1'b1);

        for (int j = 0; j < 10; j++) begin
            logic [1:0] r;
            int         k;
            r = 2'($urandom_range(1, 3));
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : -1;
            run_job(r, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 2)),
                    4'($urandom_range(0, 2)), k, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter PAT_W, default 16: pattern width; SHALL equal the downstream pulse generator ring length.
REQ-002 Parameter REP_W, default 4: width of the per-requester repeat count.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; SHALL be sampled only on the rising clock edge.
REQ-005 req  input  2  per-requester request level (bit i = requester i).
REQ-006 pattern0, pattern1  input  PAT_W  pulse pattern offered by requester 0 / 1.
REQ-007 repeats0, repeats1  input  REP_W  extra full ring rotations requested by requester 0 / 1.
REQ-008 abort  input  1  terminates the current job.
REQ-009 grant  output  2  one-hot acceptance strobe, high for exactly the LOAD cycle.
REQ-010 owner  output  1  index of the accepted requester; valid while busy=1.
REQ-011 pg_in  output  PAT_W  pattern driven to the generator's parallel input.
REQ-012 pg_load  output  1  generator load_flag.
REQ-013 busy  output  1  high in LOAD and RUN.
REQ-014 done  output  1  one-cycle completion strobe.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-016 IDLE: if req!=0, latch the winner's pattern, repeats and index, then go to LOAD; otherwise stay in IDLE.
REQ-017 LOAD, 1 cycle: pg_load=1, pg_in=latched pattern, grant=one-hot(winner), busy=1; go to RUN with cycle counter=0 and rotation counter=0.
REQ-018 RUN: pg_load=0, pg_in held, busy=1; 4-bit cycle counter increments every cycle and wraps 15->0.
REQ-019 On a RUN cycle with cycle counter=15: if rotation counter equals latched repeats, go to DONE; otherwise increment the rotation counter.
REQ-020 RUN SHALL last exactly 16*(repeats+1) cycles, so repeats=0 gives 16 cycles and repeats=15 gives 256 cycles.
REQ-021 DONE, 1 cycle: done=1, busy=0, then IDLE; requests present during DONE SHALL NOT be accepted until IDLE.
REQ-022 abort=1 in LOAD or RUN: next state IDLE, done never asserted for that job, busy=0 from the next cycle.
REQ-023 abort in IDLE or DONE SHALL be ignored.
REQ-024 abort together with the final RUN cycle: abort wins and done is not asserted.
REQ-025 Request inputs and pattern inputs SHALL be ignored outside IDLE; a requester deasserting req after acceptance SHALL NOT affect the job.
REQ-026 grant SHALL never be two-hot; at most one grant pulse per job.

Reset
REQ-027 reset=1: state IDLE; grant, owner, pg_in, pg_load, busy and done = 0; both counters = 0; round-robin last-grant pointer = 1, so requester 0 is preferred first.
REQ-028 reset mid-LOAD or mid-RUN: all outputs SHALL read 0 in the cycle after the edge, with no done pulse.
REQ-029 reset SHALL take priority over abort and req.

Configuration
REQ-030 Macro PULSE_SEQ_ROUND_ROBIN_EN defined: when req=2'b11 in IDLE, the winner SHALL be the requester not granted last; the pointer updates on every grant.
REQ-031 Macro PULSE_SEQ_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins over requester 1; no pointer register.

Verification
REQ-032 Reset for 2 cycles, then release -> all outputs 0, and busy stays 0 while req=0.
REQ-033 req=01, pattern0=16'h8001, repeats0=0 -> next cycle grant=01, pg_load=1, pg_in=16'h8001; busy high for 17 cycles; done=1 on the 18th cycle after the request edge.
REQ-034 req=11 held for three jobs, repeats=0 -> with macro, grants 01, 10, 01; without macro, grants 01, 01, 01.
REQ-035 repeats1=4'hF, req=10 -> RUN lasts 256 cycles and owner=1 throughout; abort asserted on RUN cycle 100 in a repeat run -> IDLE next cycle with no done pulse.
REQ-036 reset asserted on RUN cycle 5 -> all outputs 0 next cycle; a subsequent req=01 starts a fresh job with a LOAD cycle.
REQ-037 abort and the final RUN cycle coincide -> done stays 0; req asserted during DONE -> grant appears only after the IDLE cycle.
